// File: rtl/mem_pkg.sv
// Shared types and constants for the wait-state memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } memstate_t;

  localparam int WORD_BYTES = 4;
  localparam int CNT_W      = 4;

endpackage

// File: rtl/mem_array.sv
// Word storage: combinational read, synchronous write-enable, no reset.
module mem_array #(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_idx,
  input  logic [31:0]           i_wd,
  output logic [31:0]           o_rd
);

  logic [31:0] r_mem [2**DEPTH_LOG2];

  // NOTE: the storage array has no reset branch; clearing every word would
  // force flops instead of RAM and contents must survive a core reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_idx] <= i_wd;
  end

  assign o_rd = r_mem[i_idx];

endmodule

// File: rtl/mem_responder.sv
// Req/ready memory responder with LATENCY wait states for the multicycle MIPS port.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 6,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        ready,
  output logic        err
);

  localparam int                AW     = DEPTH_LOG2 + 2;
  localparam logic [CNT_W-1:0]  LAT_M1 = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  memstate_t             r_state;
  memstate_t             w_next_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [AW-1:0]         r_adr;
  logic [31:0]           r_wd;
  logic                  r_we;
  logic [31:0]           r_rd;
  logic                  r_err;

  logic [AW-1:0]         w_acc_adr;
  logic [31:0]           w_acc_wd;
  logic                  w_acc_we;
  logic                  w_aligned;
  logic                  w_enter_resp;
  logic                  w_mem_we;
  logic [31:0]           w_mem_rd;
  logic                  w_unused_adr;

  // Address bits above the array are deliberately ignored (aliasing).
  assign w_unused_adr = ^adr[31:AW];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: the default assignment at the top keeps this block free of latches.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (req) w_next_state = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (r_cnt == CNT_ONE) w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    ready = (r_state == RESP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: if (req) begin
          r_adr <= adr[AW-1:0];
          r_wd  <= wd;
          r_we  <= we;
          r_cnt <= LAT_M1;
        end
        WAIT: if (r_cnt != CNT_ONE) r_cnt <= r_cnt - CNT_ONE;
        default: ;
      endcase
    end
  end

  // With LATENCY=1 the access happens on the accepting edge, before capture.
  assign w_acc_adr    = (r_state == IDLE) ? adr[AW-1:0] : r_adr;
  assign w_acc_wd     = (r_state == IDLE) ? wd          : r_wd;
  assign w_acc_we     = (r_state == IDLE) ? we          : r_we;
  assign w_aligned    = (w_acc_adr[1:0] == 2'(WORD_BYTES - 4));
  assign w_enter_resp = (w_next_state == RESP) && (r_state != RESP) && !reset;
  assign w_mem_we     = w_enter_resp && w_acc_we && w_aligned;

  mem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_mem_array (
    .clk  (clk),
    .i_we (w_mem_we),
    .i_idx(w_acc_adr[AW-1:2]),
    .i_wd (w_acc_wd),
    .o_rd (w_mem_rd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd  <= '0;
      r_err <= 1'b0;
    end else if (w_enter_resp) begin
      if (!w_aligned) begin
        r_rd  <= '0;
        r_err <= 1'b1;
      end else begin
        r_rd  <= w_acc_we ? w_acc_wd : w_mem_rd;
        r_err <= 1'b0;
      end
    end else if (r_state == RESP) begin
      r_err <= 1'b0;
    end
  end

  assign rd  = r_rd;
  assign err = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (LATENCY 2, 4, 1) against a word-array model.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [31:0] adr;
  logic [31:0] wd;
  int          sel;

  logic        req_l   [3];
  logic [31:0] rd_l    [3];
  logic        ready_l [3];
  logic        err_l   [3];

  int lat_of [3] = '{2, 4, 1};

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mdl_mem   [3][64];
  bit          mdl_known [3][64];

  typedef struct {
    int          s;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [12];

  always #5 clk = ~clk;

  assign req_l[0] = req && (sel == 0);
  assign req_l[1] = req && (sel == 1);
  assign req_l[2] = req && (sel == 2);

  mem_responder #(.DEPTH_LOG2(6), .LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset), .req(req_l[0]), .we(we), .adr(adr), .wd(wd),
    .rd(rd_l[0]), .ready(ready_l[0]), .err(err_l[0]));

  mem_responder #(.DEPTH_LOG2(6), .LATENCY(4)) u_l4 (
    .clk(clk), .reset(reset), .req(req_l[1]), .we(we), .adr(adr), .wd(wd),
    .rd(rd_l[1]), .ready(ready_l[1]), .err(err_l[1]));

  mem_responder #(.DEPTH_LOG2(6), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .req(req_l[2]), .we(we), .adr(adr), .wd(wd),
    .rd(rd_l[2]), .ready(ready_l[2]), .err(err_l[2]));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Expected response from the word-array view: aliasing by modulo, misaligned -> err.
  task automatic predict(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] e_rd, output logic e_err, output bit rd_known);
    int idx;
    idx = int'((a / 4) % 64);
    rd_known = 1'b1;
    if (a % 4 != 0) begin
      e_rd = 32'h0; e_err = 1'b1;
    end else if (w) begin
      e_rd = d; e_err = 1'b0;
    end else begin
      e_rd = mdl_mem[s][idx]; e_err = 1'b0; rd_known = mdl_known[s][idx];
    end
  endtask

  // Called at a negedge with the selected DUT idle; returns at the negedge after ready.
  task automatic run_check(input string name, input int s, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] e_rd, input logic e_err,
                           input bit chk_rd);
    int          lat;
    logic [31:0] got_rd;
    logic        got_err;
    int          idx;
    sel = s; req = 1'b1; we = w; adr = a; wd = d;
    @(posedge clk); #1;
    // Dropping req and scrambling inputs must not disturb the accepted transaction.
    req = 1'b0; we = 1'($urandom_range(0, 1)); adr = $urandom; wd = $urandom;
    lat = -1; got_rd = '0; got_err = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ready_l[s]) begin
        lat = k; got_rd = rd_l[s]; got_err = err_l[s];
        break;
      end
    end
    check({name, "_latency"}, lat, lat_of[s]);
    check({name, "_err"}, 32'(got_err), 32'(e_err));
    if (chk_rd) check({name, "_rd"}, got_rd, e_rd);
    @(negedge clk);
    check({name, "_ready_drop"}, 32'(ready_l[s]), 32'h0);
    check({name, "_err_clear"}, 32'(err_l[s]), 32'h0);
    check({name, "_rd_hold"}, rd_l[s], got_rd);
    idx = int'((a / 4) % 64);
    if (w && (a % 4 == 0)) begin
      mdl_mem[s][idx] = d; mdl_known[s][idx] = 1'b1;
    end
  endtask

  task automatic watch_no_ready(input string name, input int s, input int cycles);
    int seen;
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (ready_l[s]) seen++;
    end
    check(name, 32'(seen), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e_rd;
    logic        e_err;
    bit          known;
    int          first_k, second_k, pulses, adjacent;
    logic        prev_ready;

    for (int s = 0; s < 3; s++)
      for (int i = 0; i < 64; i++) begin
        mdl_mem[s][i] = '0; mdl_known[s][i] = 1'b0;
      end

    vecs[0]  = '{0, 1'b1, 32'h10,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    vecs[1]  = '{0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{0, 1'b1, 32'h13,  32'h12345678, 32'h0,        1'b1};
    vecs[3]  = '{0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
    vecs[4]  = '{0, 1'b1, 32'h100, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0};
    vecs[5]  = '{0, 1'b0, 32'h0,   32'h0,        32'hA5A5A5A5, 1'b0};
    vecs[6]  = '{0, 1'b1, 32'h24,  32'h99990009, 32'h99990009, 1'b0};
    vecs[7]  = '{0, 1'b1, 32'h28,  32'h28282828, 32'h28282828, 1'b0};
    vecs[8]  = '{2, 1'b1, 32'h8,   32'h01020304, 32'h01020304, 1'b0};
    vecs[9]  = '{2, 1'b0, 32'h8,   32'h0,        32'h01020304, 1'b0};
    vecs[10] = '{2, 1'b0, 32'h9,   32'h0,        32'h0,        1'b1};
    vecs[11] = '{1, 1'b1, 32'h20,  32'h11112222, 32'h11112222, 1'b0};

    reset = 1'b1; req = 1'b0; we = 1'b0; adr = '0; wd = '0; sel = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check($sformatf("reset_ready%0d", s), 32'(ready_l[s]), 32'h0);
      check($sformatf("reset_err%0d", s),   32'(err_l[s]),   32'h0);
      check($sformatf("reset_rd%0d", s),    rd_l[s],         32'h0);
    end

    for (int i = 0; i < 12; i++)
      run_check($sformatf("vec%0d", i), vecs[i].s, vecs[i].w, vecs[i].a, vecs[i].d,
                vecs[i].exp_rd, vecs[i].exp_err, 1'b1);

    // Reset coinciding with req: the request must not be accepted.
    sel = 0; req = 1'b1; we = 1'b0; adr = 32'h10; reset = 1'b1;
    @(posedge clk); #1;
    req = 1'b0; reset = 1'b0;
    watch_no_ready("reset_with_req", 0, 6);

    // LATENCY=4 write aborted by reset in the second WAIT cycle.
    sel = 1; req = 1'b1; we = 1'b1; adr = 32'h20; wd = 32'hCAFEF00D;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    watch_no_ready("abort_no_ready", 1, 8);
    check("abort_rd_cleared", rd_l[1], 32'h0);
    check("abort_err_cleared", 32'(err_l[1]), 32'h0);
    run_check("abort_readback", 1, 1'b0, 32'h20, 32'h0, 32'h11112222, 1'b0, 1'b1);

    // Back-to-back reads with req held; address switched after the first ready.
    sel = 0; req = 1'b1; we = 1'b0; adr = 32'h28;
    first_k = -1; second_k = -1; pulses = 0; adjacent = 0; prev_ready = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ready_l[0] && prev_ready) adjacent++;
      prev_ready = ready_l[0];
      if (ready_l[0]) begin
        pulses++;
        if (pulses == 1) begin
          first_k = k;
          check("b2b_first_rd", rd_l[0], 32'h28282828);
          adr = 32'h24;
        end else begin
          second_k = k;
          check("b2b_second_rd", rd_l[0], 32'h99990009);
          req = 1'b0;
          break;
        end
      end
    end
    check("b2b_first_latency", 32'(first_k), 32'd2);
    check("b2b_spacing", 32'(second_k - first_k), 32'd3);
    check("b2b_adjacent", 32'(adjacent), 32'h0);
    @(negedge clk);

    // Randomised traffic against the word-array model on every instance.
    for (int s = 0; s < 3; s++) begin
      for (int t = 0; t < 40; t++) begin
        logic        w;
        logic [31:0] a, d, r;
        int          low, idx;
        w   = 1'($urandom_range(0, 1));
        low = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
        idx = int'($urandom_range(0, 15));
        r   = $urandom;
        a   = (r & 32'hFFFF_FF00) | 32'(idx << 2) | 32'(low);
        d   = $urandom;
        predict(s, w, a, d, e_rd, e_err, known);
        run_check($sformatf("rnd_s%0d_t%0d", s, t), s, w, a, d, e_rd, e_err, known);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
